// File: rtl/pu_play_driver_if.sv
// Bus between the play driver and the processing unit under test.
// The master side drives strobes and operands; the slave side returns the result.
interface pu_play_driver_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4
);
  logic                  signal_wr;
  logic                  signal_sel;
  logic                  signal_oe;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ATTR_WIDTH-1:0] attr_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ATTR_WIDTH-1:0] attr_out;

  modport master (
    output signal_wr, signal_sel, signal_oe, data_in, attr_in,
    input  data_out, attr_out
  );

  modport slave (
    input  signal_wr, signal_sel, signal_oe, data_in, attr_in,
    output data_out, attr_out
  );
endinterface

// File: rtl/pu_play_driver.sv
// Board harness for a single PU: runs load A / load B / wait / read sequences,
// advances the operands and shows a selectable slice of the result on LEDs.
module pu_play_driver #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ATTR_WIDTH     = 4,
  parameter int unsigned INVALID        = 1,
  parameter int unsigned LED_WIDTH      = 8,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned PRESCALE_WIDTH = 24,
  parameter int unsigned DEBOUNCE       = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 RUN_MODE,
  input  logic                 SPEED,
  input  logic                 STEP_KEY,
  input  logic [1:0]           LED_SEL,
  pu_play_driver_if.master     pu,
  output logic [LED_WIDTH-1:0] LED,
  output logic                 ERR,
  output logic [15:0]          seq_count
);

  localparam int unsigned NSLICE = DATA_WIDTH / LED_WIDTH;
  localparam int unsigned DBW    = $clog2(DEBOUNCE + 1);
  localparam int unsigned WW     = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_READ, S_SHOW
  } state_t;

  state_t                  state_q;
  logic                    wr_q, sel_q, oe_q;
  logic [DATA_WIDTH-1:0]   data_in_q;
  logic [WW-1:0]           wait_q;
  logic [DATA_WIDTH-1:0]   op_a_q, op_b_q, result_q;
  logic                    err_q;
  logic [15:0]             seq_q;

  logic [1:0]              sync_q;
  logic                    deb_q, press_q;
  logic [DBW-1:0]          deb_cnt_q;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                    tick_slow, tick_fast, tick;
  logic                    unused_attr;

  // Key conditioning: a change is accepted only after DEBOUNCE stable samples.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], STEP_KEY};
      press_q <= 1'b0;
      if (sync_q[1] == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DBW'(DEBOUNCE - 1)) begin
        deb_q     <= sync_q[1];
        deb_cnt_q <= '0;
        press_q   <= sync_q[1];
      end else begin
        deb_cnt_q <= deb_cnt_q + DBW'(1);
      end
    end
  end

  assign presc_d = presc_q + PRESCALE_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (RST) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign tick_slow = &presc_q;
  assign tick_fast = &presc_q[PRESCALE_WIDTH-5:0];
  assign tick      = RUN_MODE ? (SPEED ? tick_fast : tick_slow) : press_q;

  // Strobes are set on entry to a state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      oe_q      <= 1'b0;
      data_in_q <= '0;
      wait_q    <= '0;
      op_a_q    <= DATA_WIDTH'(1);
      op_b_q    <= DATA_WIDTH'(2);
      result_q  <= '0;
      err_q     <= 1'b0;
      seq_q     <= '0;
    end else begin
      wr_q  <= 1'b0;
      sel_q <= 1'b0;
      oe_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (tick) begin
          state_q   <= S_LOAD_A;
          wr_q      <= 1'b1;
          data_in_q <= op_a_q;
        end
        S_LOAD_A: begin
          state_q   <= S_LOAD_B;
          wr_q      <= 1'b1;
          sel_q     <= 1'b1;
          data_in_q <= op_b_q;
        end
        S_LOAD_B: begin
          state_q <= S_WAIT;
          wait_q  <= '0;
        end
        S_WAIT: if (wait_q == WW'(LATENCY - 1)) begin
          state_q <= S_READ;
          oe_q    <= 1'b1;
        end else begin
          wait_q <= wait_q + WW'(1);
        end
        S_READ: begin
          state_q  <= S_SHOW;
          result_q <= pu.data_out;
          err_q    <= err_q | pu.attr_out[INVALID];
          op_a_q   <= op_a_q + DATA_WIDTH'(1);
          op_b_q   <= op_b_q + DATA_WIDTH'(3);
          seq_q    <= seq_q + 16'd1;
        end
        S_SHOW:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    LED = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (32'(LED_SEL) == i) LED = result_q[i*LED_WIDTH +: LED_WIDTH];
    end
  end

  assign pu.signal_wr  = wr_q;
  assign pu.signal_sel = sel_q;
  assign pu.signal_oe  = oe_q;
  assign pu.data_in    = data_in_q;
  assign pu.attr_in    = data_in_q[ATTR_WIDTH-1:0];
  assign ERR           = err_q;
  assign seq_count     = seq_q;
  assign unused_attr   = ^pu.attr_out;

endmodule
